shift_register_piso_core: RTL and testbench

SHIFT_REGISTER_PISO_CORE -- requirements
Module: shift_register_PISO

---
 rtl/shift_register_piso_core.sv | 43 ++++
 tb/tb_shift_register_piso_core.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/shift_register_piso_core.sv
// Parallel-in / serial-out shift register.
// A parallel word is captured on any edge with shift low. Each edge with shift
// high moves it one place toward the serial end, and FILL_BIT enters the far end.
// Once the word has been fully shifted out, the register holds only FILL_BIT.
// The serial output is taken straight from the end bit of the register, so the
// first bit is visible right after the load edge. There is no output pipeline.
module shift_register_piso_core #(
  parameter int   WIDTH     = 4,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             q_out
);

  logic [WIDTH-1:0] sreg;

  // Reset wins over everything. Otherwise, load the word or advance it one position toward the serial end.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
    end else if (!shift) begin
      sreg <= data;
    end else if (MSB_FIRST) begin
      sreg <= {sreg[WIDTH-2:0], FILL_BIT};
    end else begin
      sreg <= {FILL_BIT, sreg[WIDTH-1:1]};
    end
  end

  // The serial end depends on the shift direction; q_out is a plain wire from that register bit.
  generate
    if (MSB_FIRST) begin : gen_msb_end
      assign q_out = sreg[WIDTH-1];
    end else begin : gen_lsb_end
      assign q_out = sreg[0];
    end
  endgenerate

endmodule

// File: tb/tb_shift_register_piso_core.sv
// Self-checking bench for shift_register_piso_core.
// Two instances share one stimulus stream:
//   - dut_msb uses the default parameters (MSB-first, fill 0).
//   - dut_lsb runs LSB-first with fill 1.
// The reference model keeps only the last loaded word and the number of shifts
// since that load. The expected serial bit follows directly from those two values.
module tb_shift_register_piso_core;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         shift;
  logic [W-1:0] data;
  logic         q_msb;
  logic         q_lsb;

  int checks = 0;
  int passed = 0;

  logic [W-1:0] model_word;
  int           model_shifts;
  bit           model_valid = 1'b0;

  shift_register_piso_core #(.WIDTH(W), .MSB_FIRST(1'b1), .FILL_BIT(1'b0)) dut_msb (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .data  (data),
    .q_out (q_msb)
  );

  shift_register_piso_core #(.WIDTH(W), .MSB_FIRST(1'b0), .FILL_BIT(1'b1)) dut_lsb (
    .clk   (clk),
    .rst   (rst),
    .shift (shift),
    .data  (data),
    .q_out (q_lsb)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value differs from the expected one
  task automatic checkOutput(input string tag, input logic actual, input logic expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
    else
      passed++;
  endtask

  // Serial bit expected from the model for a given direction and fill value
  function automatic logic expectBit(input bit msb_first, input logic fill);
    if (model_shifts >= W) return fill;
    if (msb_first) return model_word[W-1-model_shifts];
    return model_word[model_shifts];
  endfunction

  // Drives one edge and advances the model.
  // It then checks both outputs, perturbs data and shift between edges,
  // and confirms that the outputs hold their values.
  task automatic applyStimulus(input string tag, input logic r, input logic s, input logic [W-1:0] d);
    rst   = r;
    shift = s;
    data  = d;
    @(posedge clk);
    if (r) begin
      model_word   = '0;
      model_shifts = 0;
      model_valid  = 1'b1;
    end else if (!s) begin
      model_word   = d;
      model_shifts = 0;
    end else if (model_shifts < W) begin
      model_shifts++;
    end
    #1;
    if (model_valid) begin
      checkOutput({tag, ".msb"}, q_msb, expectBit(1'b1, 1'b0));
      checkOutput({tag, ".lsb"}, q_lsb, expectBit(1'b0, 1'b1));
      data  = ~d;
      shift = ~s;
      #1;
      checkOutput({tag, ".msb_hold"}, q_msb, expectBit(1'b1, 1'b0));
      checkOutput({tag, ".lsb_hold"}, q_lsb, expectBit(1'b0, 1'b1));
    end
  endtask

  initial begin
    rst   = 1'b0;
    shift = 1'b0;
    data  = '0;

    // Reset with a load pending, then a load of all ones
    applyStimulus("rst", 1'b1, 1'b0, 4'b1111);
    checkOutput("rst_q0", q_msb, 1'b0);
    applyStimulus("rst_rel", 1'b0, 1'b0, 4'b1111);
    checkOutput("rst_rel_q1", q_msb, 1'b1);

    // Shift out 0101 MSB-first, one edge past the end
    applyStimulus("ld0101", 1'b0, 1'b0, 4'b0101);
    checkOutput("ld0101_q", q_msb, 1'b0);
    applyStimulus("sh0101_1", 1'b0, 1'b1, 4'b0000);
    checkOutput("sh0101_1_q", q_msb, 1'b1);
    applyStimulus("sh0101_2", 1'b0, 1'b1, 4'b1111);
    checkOutput("sh0101_2_q", q_msb, 1'b0);
    applyStimulus("sh0101_3", 1'b0, 1'b1, 4'b0000);
    checkOutput("sh0101_3_q", q_msb, 1'b1);
    applyStimulus("sh0101_4", 1'b0, 1'b1, 4'b1111);
    checkOutput("sh0101_4_q", q_msb, 1'b0);
    applyStimulus("sh0101_5", 1'b0, 1'b1, 4'b1111);
    checkOutput("sh0101_5_q", q_msb, 1'b0);

    // Shift out 1010
    applyStimulus("ld1010", 1'b0, 1'b0, 4'b1010);
    checkOutput("ld1010_q", q_msb, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("sh1010", 1'b0, 1'b1, 4'($urandom));

    // Mid-stream reload discards the remaining bits
    applyStimulus("ld1100", 1'b0, 1'b0, 4'b1100);
    applyStimulus("sh1100", 1'b0, 1'b1, 4'b0000);
    checkOutput("sh1100_q", q_msb, 1'b1);
    applyStimulus("reld0011", 1'b0, 1'b0, 4'b0011);
    checkOutput("reld0011_q", q_msb, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus("sh0011", 1'b0, 1'b1, 4'b1111);

    // Reset in the middle of shifting, then keep shifting
    applyStimulus("ld1111", 1'b0, 1'b0, 4'b1111);
    applyStimulus("sh1111", 1'b0, 1'b1, 4'b0000);
    applyStimulus("sh1111", 1'b0, 1'b1, 4'b0000);
    applyStimulus("midrst", 1'b1, 1'b1, 4'b1111);
    checkOutput("midrst_q", q_msb, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus("postrst", 1'b0, 1'b1, 4'b1111);
    checkOutput("postrst_q", q_msb, 1'b0);

    // LSB-first instance shifting out 0110, then into its fill region
    applyStimulus("ld0110", 1'b0, 1'b0, 4'b0110);
    checkOutput("lsb_ld_q", q_lsb, 1'b0);
    applyStimulus("lsb_sh1", 1'b0, 1'b1, 4'b0000);
    checkOutput("lsb_sh1_q", q_lsb, 1'b1);
    applyStimulus("lsb_sh2", 1'b0, 1'b1, 4'b0000);
    checkOutput("lsb_sh2_q", q_lsb, 1'b1);
    applyStimulus("lsb_sh3", 1'b0, 1'b1, 4'b0000);
    checkOutput("lsb_sh3_q", q_lsb, 1'b0);
    applyStimulus("lsb_sh4", 1'b0, 1'b1, 4'b0000);
    checkOutput("lsb_fill_q", q_lsb, 1'b1);

    // Repeated loads track data edge by edge
    for (int i = 0; i < 8; i++) applyStimulus("reload", 1'b0, 1'b0, 4'($urandom));

    // Random mix of resets, loads and shifts
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), 4'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
